alu_iter: RTL and testbench

Multi-cycle execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder plus two operands, and returns a registered result and zero flag. Add/sub/logic/compare complete in one cycle. Shifts run on a 1-bit-per-cycle serial shifter, so area stays small, unless the barrel shifter is compiled in. A valid/ready input handshake and a one-cycle done pulse let the controller stall while a shift is in flight.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_iter_if.sv | 17 +
 rtl/alu_shift_serial.sv | 50 +++++
 rtl/alu_iter.sv | 122 ++++++++++++
 tb/tb_alu_iter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings, controller state and shift-kind enums.
// The codes match the ALU decoder that drives ALUControl.
package alu_pkg;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b0001;
    localparam logic [3:0] ALU_AND      = 4'b0010;
    localparam logic [3:0] ALU_OR       = 4'b0011;
    localparam logic [3:0] ALU_SLL_SLLI = 4'b0100;
    localparam logic [3:0] ALU_SLT      = 4'b0101;
    localparam logic [3:0] ALU_SLTU     = 4'b0110;
    localparam logic [3:0] ALU_XOR      = 4'b0111;
    localparam logic [3:0] ALU_SRL_SRLI = 4'b1000;
    localparam logic [3:0] ALU_SRA_SRAI = 4'b1001;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef enum logic [1:0] {SH_L, SH_RL, SH_RA} shkind_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL_SLLI) || (code == ALU_SRL_SRLI) || (code == ALU_SRA_SRAI);
    endfunction

    function automatic shkind_t shift_kind(input logic [3:0] code);
        shkind_t k;
        k = SH_RL;
        if (code == ALU_SLL_SLLI) k = SH_L;
        if (code == ALU_SRA_SRAI) k = SH_RA;
        return k;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Execute-stage ALU port bundle: valid/ready operand handshake plus done/Result/Zero return.
// master = controller side, slave = alu_iter.
interface alu_iter_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Zero;

    modport master (output in_valid, SrcA, SrcB, ALUControl,
                    input  in_ready, done, Result, Zero);
    modport slave  (input  in_valid, SrcA, SrcB, ALUControl,
                    output in_ready, done, Result, Zero);
endinterface

// File: rtl/alu_shift_serial.sv
// One-bit-per-cycle shifter: shift register, remaining count and kind, loaded on accept.
// last marks the step whose dnext is the final shifted value.
module alu_shift_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  shkind_t          kind_in,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dnext,
    output logic             last
);

    logic [WIDTH-1:0] sreg;
    logic [SHW-1:0]   cnt;
    shkind_t          kind_q;

    always_comb begin
        dnext = sreg;
        case (kind_q)
            SH_L:    dnext = {sreg[WIDTH-2:0], 1'b0};
            SH_RL:   dnext = {1'b0, sreg[WIDTH-1:1]};
            SH_RA:   dnext = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
            default: dnext = sreg;
        endcase
    end

    assign last = (cnt == SHW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg   <= '0;
            cnt    <= '0;
            kind_q <= SH_L;
        end else if (load) begin
            sreg   <= din;
            cnt    <= amt;
            kind_q <= kind_in;
        end else if (cnt != '0) begin
            sreg <= dnext;
            cnt  <= cnt - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle execute ALU: single-cycle arithmetic/logic, serial shifts unless
// ALU_ITER_BARREL_SHIFT_EN selects a one-cycle barrel shifter.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_iter_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a, b, res_c, wr_val, result_q;
    logic [3:0]       code;
    logic [SHW-1:0]   amt;
    logic             rdy, accept, single, wr, zero_q, done_q;

    assign a      = bus.SrcA;
    assign b      = bus.SrcB;
    assign code   = bus.ALUControl;
    assign amt    = b[SHW-1:0];
    assign accept = bus.in_valid && rdy;

    always_comb begin
        res_c = '0;
        case (code)
            ALU_ADD:      res_c = a + b;
            ALU_SUB:      res_c = a - b;
            ALU_AND:      res_c = a & b;
            ALU_OR:       res_c = a | b;
            ALU_XOR:      res_c = a ^ b;
            ALU_SLT:      res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:     res_c = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_ITER_BARREL_SHIFT_EN
            ALU_SLL_SLLI: res_c = a << amt;
            ALU_SRL_SRLI: res_c = a >> amt;
            ALU_SRA_SRAI: res_c = WIDTH'($signed(a) >>> amt);
`else
            // Only zero-amount shifts take this path; the rest go through the serial shifter.
            ALU_SLL_SLLI, ALU_SRL_SRLI, ALU_SRA_SRAI: res_c = a;
`endif
            default:      res_c = '0;
        endcase
    end

`ifdef ALU_ITER_BARREL_SHIFT_EN
    assign rdy    = !reset;
    assign single = accept;
    assign wr     = single;
    assign wr_val = res_c;
`else
    state_t           state_q, state_d;
    logic             shift_go, load, fin, last;
    logic [WIDTH-1:0] sh_next;

    assign shift_go = is_shift(code) && (amt != '0);
    assign rdy      = (state_q == IDLE) && !reset;
    assign single   = accept && !shift_go;

    alu_shift_serial #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .kind_in (shift_kind(code)),
        .amt     (amt),
        .din     (a),
        .dnext   (sh_next),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && shift_go) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr     = single || fin;
    assign wr_val = fin ? sh_next : res_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= wr;
            if (wr) begin
                result_q <= wr_val;
                zero_q   <= (wr_val == '0);
            end
        end
    end

    assign bus.in_ready = rdy;
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed plus randomized bench for alu_iter against an arithmetic reference model.
// Latency expectations follow ALU_ITER_BARREL_SHIFT_EN when it is defined.
module tb_alu_iter;

`ifdef ALU_ITER_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_iter_if #(.WIDTH(32)) bus ();

    alu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic bit tb_is_shift(input logic [3:0] c);
        return (c == 4'd4) || (c == 4'd8) || (c == 4'd9);
    endfunction

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned k;
        logic [63:0] p;
        longint sa, d, q;
        k = b[4:0];
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: begin
                p = {32'b0, a} * (64'd1 << k);
                return p[31:0];
            end
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a ^ b;
            4'd8: return a / (32'd1 << k);
            4'd9: begin
                sa = longint'($signed(a));
                d  = longint'(1) << k;
                q  = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                return q[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int lat, rlow, el;
        logic [31:0] er;
        er = model(c, a, b);
        el = (!BARREL && tb_is_shift(c) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUControl = c;
        bus.SrcA = a;
        bus.SrcB = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        bus.ALUControl = 4'($urandom);
        lat = 1;
        rlow = 0;
        while (!bus.done && lat < 64) begin
            if (!bus.in_ready) rlow++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_res"}, bus.Result, er);
        check({tag, "_zero"}, 32'(bus.Zero), 32'(er == 32'd0));
        check({tag, "_rdylow"}, 32'(rlow), 32'(el - 1));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat, dcount;
        logic [3:0] rc;
        bus.in_valid = 1'b0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        bus.ALUControl = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_res", bus.Result, 32'd0);
        check("rst_zero", 32'(bus.Zero), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

        // back-to-back ADD then SUB
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUControl = 4'd0;
        bus.SrcA = 32'h7FFF_FFFF;
        bus.SrcB = 32'd1;
        @(posedge clk); #1;
        check("add_done", 32'(bus.done), 32'd1);
        check("add_res", bus.Result, 32'h8000_0000);
        check("add_zero", 32'(bus.Zero), 32'd0);
        check("add_rdy", 32'(bus.in_ready), 32'd1);
        bus.ALUControl = 4'd1;
        bus.SrcA = 32'd5;
        bus.SrcB = 32'd5;
        @(posedge clk); #1;
        check("sub_done", 32'(bus.done), 32'd1);
        check("sub_res", bus.Result, 32'd0);
        check("sub_zero", 32'(bus.Zero), 32'd1);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_pulse", 32'(bus.done), 32'd0);

        run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1);
        run_op("sra4", 4'd9, 32'h8000_0000, 32'd4);
        check("sra4_val", bus.Result, 32'hF800_0000);
        run_op("sll31", 4'd4, 32'd1, 32'd31);
        check("sll31_val", bus.Result, 32'h8000_0000);
        run_op("srl0", 4'd8, 32'hDEAD_BEEF, 32'h0000_0020);

        // new op held on the bus while a shift is in flight
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUControl = 4'd9;
        bus.SrcA = 32'hF000_0000;
        bus.SrcB = 32'd3;
        @(posedge clk); #1;
        bus.ALUControl = 4'd0;
        bus.SrcA = 32'd10;
        bus.SrcB = 32'd20;
        lat = 1;
        while (!bus.done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_sh_lat", 32'(lat), BARREL ? 32'd1 : 32'd4);
        check("hold_sh_res", bus.Result, model(4'd9, 32'hF000_0000, 32'd3));
        @(posedge clk); #1;
        check("hold_add_done", 32'(bus.done), 32'd1);
        check("hold_add_res", bus.Result, 32'd30);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_add_once", 32'(bus.done), 32'd0);

        // reset in the middle of a long shift
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUControl = 4'd4;
        bus.SrcA = 32'd3;
        bus.SrcB = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_res", bus.Result, 32'd0);
        check("mid_rst_zero", 32'(bus.Zero), 32'd1);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rdy_after", 32'(bus.in_ready), 32'd1);
        dcount = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done) dcount++;
        end
        check("mid_rst_no_done", 32'(dcount), 32'd0);

        run_op("pre_undef", 4'd0, 32'd100, 32'd23);
        run_op("undef_c", 4'hC, 32'd12345, 32'd6789);

        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            run_op("rand", rc, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
